// File: rtl/mbesm_bus_pkg.sv
// rtl/mbesm_bus_pkg.sv - shared busio register, bus FSM and arbiter opcode definitions
//
// Purpose: types and constants shared by bus_port, bus_watchdog and the bus arbiter.
// Ports: none (package).
package mbesm_bus_pkg;

  // busio register index, also used by the arbiter's arx field
  typedef enum logic [1:0] {
    ADDR  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } reg_index_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    ABORT   = 2'd3
  } bus_state_e;

  // arbiter opcodes that end up as rd/wr strobes on this port
  localparam logic [3:0] DRD = 4'd9;
  localparam logic [3:0] DWR = 4'd10;

endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - wait-cycle counter that flags an expired memory request
//
// Purpose: counts cycles spent waiting on mem_ready; o_expire marks the last allowed one.
// Ports:
//   clk       in  clock, rising edge
//   reset     in  synchronous, active-high reset
//   i_clr     in  restart count at zero (transaction launch)
//   i_en      in  a wait cycle is in progress
//   o_expire  out this wait cycle is number TIMEOUT
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_expire) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = i_en && (r_count == LAST);

endmodule

// File: rtl/bus_port.sv
// rtl/bus_port.sv - busio register file and single-word external memory engine
//
// Purpose: holds ADDR/CMD/WDATA/RDATA, turns arbiter strobes into valid/ready
// memory transactions, returns read data in RDATA, reports busy/err/tmo.
// Ports:
//   clk, reset                      clock / synchronous active-high reset
//   i_cpu_we/sel/wdata, o_cpu_rdata CPU register access (read is combinational)
//   i_arx, i_ecx, i_wrx             arbiter register index, enable, load-from-memory
//   i_astb, i_rd, i_wr              address strobe, read and write requests
//   i_err_clr                       clears err and tmo
//   o_busy, o_err, o_tmo            status
//   o_mem_*/i_mem_*                 external memory request/response
module bus_port
  import mbesm_bus_pkg::*;
#(
  parameter int DW      = 64,
  parameter int AW      = 20,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_cpu_we,
  input  logic [1:0]    i_cpu_sel,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic [DW-1:0] o_cpu_rdata,
  input  logic [1:0]    i_arx,
  input  logic          i_ecx,
  input  logic          i_wrx,
  input  logic          i_astb,
  input  logic          i_rd,
  input  logic          i_wr,
  input  logic          i_err_clr,
  output logic          o_busy,
  output logic          o_err,
  output logic          o_tmo,
  output logic          o_mem_valid,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic          i_mem_ready,
  input  logic [DW-1:0] i_mem_rdata
);

  logic [DW-1:0] r_rg [0:3];
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_rd_d;
  logic          r_wr_d;
  logic          r_op_we;
  logic          r_err;
  logic          r_tmo;
  bus_state_e    r_state;
  bus_state_e    w_next;

  logic w_idle, w_wait, w_expire;
  logic w_rd_edge, w_wr_edge;
  logic w_rd_ok, w_wr_ok, w_launch_rd, w_launch_wr;
  logic w_err_set, w_tmo_set, w_rd_done;

  assign w_idle = (r_state == IDLE);
  assign w_wait = (r_state == RD_WAIT) || (r_state == WR_WAIT);

  // Only rising edges launch, so a held rd/wr cannot start a second transaction.
  assign w_rd_edge = i_rd && !r_rd_d;
  assign w_wr_edge = i_wr && !r_wr_d;

  assign w_rd_ok = i_rd && !i_wr && i_ecx && i_wrx && (i_arx == RDATA) && !i_astb;
  assign w_wr_ok = i_wr && !i_rd && i_ecx && !i_wrx && (i_arx == WDATA) && !i_astb;

  assign w_launch_rd = w_idle && w_rd_edge && w_rd_ok;
  assign w_launch_wr = w_idle && w_wr_edge && w_wr_ok;

  // Every edge that does not launch is illegal: bad combination or port busy.
  assign w_err_set = (w_rd_edge || w_wr_edge) && !(w_launch_rd || w_launch_wr);
  assign w_tmo_set = w_wait && !i_mem_ready && w_expire;
  assign w_rd_done = (r_state == RD_WAIT) && i_mem_ready;

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_launch_rd || w_launch_wr),
    .i_en     (w_wait),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_launch_rd)      w_next = RD_WAIT;
        else if (w_launch_wr) w_next = WR_WAIT;
      end
      RD_WAIT, WR_WAIT: begin
        if (i_mem_ready)   w_next = IDLE;
        else if (w_expire) w_next = ABORT;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) r_rg[k] <= '0;
    end else begin
      if (i_cpu_we) r_rg[i_cpu_sel] <= i_cpu_wdata;
      // memory completion overrides a same-cycle CPU write to RDATA
      if (w_rd_done) r_rg[RDATA] <= i_mem_rdata;
      else if (r_state == ABORT && !r_op_we) r_rg[RDATA] <= '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_op_we <= 1'b0;
      r_rd_d  <= 1'b0;
      r_wr_d  <= 1'b0;
      r_err   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_rd_d <= i_rd;
      r_wr_d <= i_wr;
      // Latch frozen while busy so the in-flight address stays stable;
      // a same-cycle CPU write to ADDR is forwarded into the latch.
      if (w_idle && i_astb && i_ecx && (i_arx == ADDR)) begin
        r_addr <= (i_cpu_we && (i_cpu_sel == ADDR)) ? i_cpu_wdata[AW-1:0]
                                                    : r_rg[ADDR][AW-1:0];
      end
      if (w_launch_wr) r_wdata <= r_rg[WDATA];
      if (w_launch_rd)      r_op_we <= 1'b0;
      else if (w_launch_wr) r_op_we <= 1'b1;
      r_err <= (r_err && !i_err_clr) || w_err_set;
      r_tmo <= (r_tmo && !i_err_clr) || w_tmo_set;
    end
  end

  assign o_cpu_rdata = r_rg[i_cpu_sel];
  assign o_busy      = !w_idle;
  assign o_err       = r_err;
  assign o_tmo       = r_tmo;
  assign o_mem_valid = w_wait;
  assign o_mem_we    = (r_state == WR_WAIT);
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;

endmodule

// File: tb/tb_bus_port.sv
// tb/tb_bus_port.sv - self-checking bench for bus_port
module tb_bus_port;

  localparam int DW = 64;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_cpu_we;
  logic [1:0]    i_cpu_sel;
  logic [DW-1:0] i_cpu_wdata;
  logic [DW-1:0] o_cpu_rdata;
  logic [1:0]    i_arx;
  logic          i_ecx, i_wrx, i_astb, i_rd, i_wr, i_err_clr;
  logic          o_busy, o_err, o_tmo, o_mem_valid, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_ready;
  logic [DW-1:0] i_mem_rdata;

  bus_port #(.DW(DW), .AW(AW), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_cpu_we(i_cpu_we), .i_cpu_sel(i_cpu_sel), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_rdata(o_cpu_rdata),
    .i_arx(i_arx), .i_ecx(i_ecx), .i_wrx(i_wrx), .i_astb(i_astb),
    .i_rd(i_rd), .i_wr(i_wr), .i_err_clr(i_err_clr),
    .o_busy(o_busy), .o_err(o_err), .o_tmo(o_tmo),
    .o_mem_valid(o_mem_valid), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    bit rd, wr, ecx, wrx;
    logic [1:0] arx;
    bit astb;
  } illeg_t;

  req_t          q_req[$];
  logic [DW-1:0] q_rd[$];
  int            total = 0;
  int            bad = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes;
    i_rd = 0; i_wr = 0; i_ecx = 0; i_wrx = 0; i_arx = 2'd0; i_astb = 0;
  endtask

  task automatic cpu_write(input logic [1:0] sel, input logic [DW-1:0] d);
    i_cpu_we = 1; i_cpu_sel = sel; i_cpu_wdata = d;
    tick;
    i_cpu_we = 0;
  endtask

  task automatic rd_reg(input logic [1:0] sel, output logic [DW-1:0] v);
    i_cpu_sel = sel;
    #1;
    v = o_cpu_rdata;
  endtask

  task automatic launch(input bit is_rd);
    i_ecx = 1; i_wrx = is_rd; i_arx = is_rd ? 2'd3 : 2'd2;
    if (is_rd) i_rd = 1; else i_wr = 1;
    tick;
  endtask

  // Serves one memory request: ready after `delay` wait cycles, optional CPU
  // pokes during the wait, optional CPU write to RDATA in the completion cycle.
  task automatic run_txn(input int delay, input bit collide, input bit poke, output int n);
    req_t e;
    logic [DW-1:0] v, ev;
    n = 0;
    total++;
    if (q_req.size() == 0) begin
      bad++; $display("FAIL req_queue empty before transaction");
      return;
    end
    e = q_req.pop_front();
    while (o_mem_valid === 1'b1 && n < 40) begin
      n++;
      total++;
      if (o_mem_we !== e.we || o_mem_addr !== e.addr || o_busy !== 1'b1 ||
          (e.we && o_mem_wdata !== e.wdata)) begin
        bad++;
        $display("FAIL req_hold cyc=%0d got we=%0b addr=%h wdata=%h busy=%0b want we=%0b addr=%h wdata=%h busy=1",
                 n, o_mem_we, o_mem_addr, o_mem_wdata, o_busy, e.we, e.addr, e.wdata);
      end
      i_mem_ready = (n > delay);
      if (poke && n == 1) begin i_cpu_we = 1; i_cpu_sel = 2'd2; i_cpu_wdata = 64'hFFFF; end
      if (poke && n == 2) begin i_cpu_we = 1; i_cpu_sel = 2'd0; i_cpu_wdata = 64'h77777; end
      if (collide && i_mem_ready) begin i_cpu_we = 1; i_cpu_sel = 2'd3; i_cpu_wdata = 64'h1; end
      tick;
      i_cpu_we = 0; i_mem_ready = 0;
    end
    if (o_busy === 1'b1) tick;
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL busy_after got=%0b want=0", o_busy); end
    if (q_rd.size() > 0) begin
      ev = q_rd.pop_front();
      rd_reg(2'd3, v);
      total++;
      if (v !== ev) begin bad++; $display("FAIL rg3_result got=%h want=%h", v, ev); end
    end
    tick;
    total++;
    if (o_mem_valid !== 1'b0 || o_err !== 1'b0) begin
      bad++; $display("FAIL held_no_relaunch got valid=%0b err=%0b want 0/0", o_mem_valid, o_err);
    end
    clear_strobes();
  endtask

  task automatic check_regs_zero(input string tag);
    logic [DW-1:0] v;
    for (int k = 0; k < 4; k++) begin
      rd_reg(k[1:0], v);
      total++;
      if (v !== '0) begin bad++; $display("FAIL %s rg%0d got=%h want=0", tag, k, v); end
    end
    total++;
    if (o_busy !== 0 || o_err !== 0 || o_tmo !== 0 || o_mem_valid !== 0 || o_mem_we !== 0 || o_mem_addr !== '0) begin
      bad++;
      $display("FAIL %s status got busy=%0b err=%0b tmo=%0b valid=%0b we=%0b addr=%h want all 0",
               tag, o_busy, o_err, o_tmo, o_mem_valid, o_mem_we, o_mem_addr);
    end
  endtask

  task automatic test_reset;
    reset = 1; i_cpu_we = 0; i_cpu_sel = 0; i_cpu_wdata = '0; i_err_clr = 0;
    i_mem_ready = 0; i_mem_rdata = '0;
    clear_strobes();
    tick; tick;
    reset = 0;
    check_regs_zero("reset");
  endtask

  task automatic test_read;
    int n;
    cpu_write(2'd0, 64'h1234);
    i_astb = 1; i_ecx = 1; i_arx = 2'd0;
    tick;
    clear_strobes();
    total++;
    if (o_mem_addr !== 20'h01234) begin bad++; $display("FAIL read_addr_latch got=%h want=01234", o_mem_addr); end
    i_mem_rdata = 64'hDEADBEEF;
    q_req.push_back('{we: 1'b0, addr: 20'h01234, wdata: '0});
    q_rd.push_back(64'hDEADBEEF);
    launch(1);
    run_txn(0, 0, 0, n);
    total++;
    if (n !== 1) begin bad++; $display("FAIL read_valid_cycles got=%0d want=1", n); end
  endtask

  task automatic test_write;
    int n;
    logic [DW-1:0] v;
    cpu_write(2'd2, 64'h55AA);
    // CPU write to ADDR in the strobe cycle must reach the latch
    i_cpu_we = 1; i_cpu_sel = 2'd0; i_cpu_wdata = 64'hABCD;
    i_astb = 1; i_ecx = 1; i_arx = 2'd0;
    tick;
    i_cpu_we = 0;
    clear_strobes();
    total++;
    if (o_mem_addr !== 20'h0ABCD) begin bad++; $display("FAIL addr_bypass got=%h want=0abcd", o_mem_addr); end
    q_req.push_back('{we: 1'b1, addr: 20'h0ABCD, wdata: 64'h55AA});
    launch(0);
    run_txn(3, 0, 1, n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL write_busy_cycles got=%0d want=4", n); end
    rd_reg(2'd2, v);
    total++;
    if (v !== 64'hFFFF) begin bad++; $display("FAIL wdata_poke got=%h want=ffff", v); end
    rd_reg(2'd0, v);
    total++;
    if (v !== 64'h77777) begin bad++; $display("FAIL addr_poke got=%h want=77777", v); end
  endtask

  task automatic test_timeout;
    int n;
    i_mem_rdata = 64'h5;
    q_req.push_back('{we: 1'b0, addr: 20'h0ABCD, wdata: '0});
    q_rd.push_back({DW{1'b1}});
    launch(1);
    run_txn(100, 0, 0, n);
    total++;
    if (n !== 8) begin bad++; $display("FAIL timeout_wait_cycles got=%0d want=8", n); end
    total++;
    if (o_tmo !== 1'b1) begin bad++; $display("FAIL timeout_tmo got=%0b want=1", o_tmo); end
  endtask

  task automatic test_illegal;
    illeg_t tbl [4];
    tbl[0] = '{1, 1, 1, 1, 2'd3, 0};
    tbl[1] = '{1, 0, 0, 1, 2'd3, 0};
    tbl[2] = '{0, 1, 1, 0, 2'd3, 0};
    tbl[3] = '{1, 0, 1, 1, 2'd3, 1};
    for (int k = 0; k < 4; k++) begin
      i_rd = tbl[k].rd; i_wr = tbl[k].wr; i_ecx = tbl[k].ecx;
      i_wrx = tbl[k].wrx; i_arx = tbl[k].arx; i_astb = tbl[k].astb;
      tick;
      total++;
      if (o_err !== 1'b1 || o_mem_valid !== 1'b0 || o_busy !== 1'b0) begin
        bad++; $display("FAIL illegal%0d got err=%0b valid=%0b busy=%0b want 1/0/0", k, o_err, o_mem_valid, o_busy);
      end
      clear_strobes();
      i_err_clr = 1;
      tick;
      i_err_clr = 0;
      total++;
      if (o_err !== 1'b0 || o_tmo !== 1'b0) begin
        bad++; $display("FAIL err_clr%0d got err=%0b tmo=%0b want 0/0", k, o_err, o_tmo);
      end
    end
    i_rd = 1; i_wr = 1; i_ecx = 1;
    tick;
    clear_strobes();
    tick;
    i_rd = 1; i_wr = 1; i_ecx = 1; i_err_clr = 1;
    tick;
    clear_strobes();
    i_err_clr = 0;
    total++;
    if (o_err !== 1'b1) begin bad++; $display("FAIL err_set_beats_clr got=%0b want=1", o_err); end
    i_err_clr = 1;
    tick;
    i_err_clr = 0;
  endtask

  task automatic test_collision;
    int n;
    i_mem_rdata = 64'h0123_4567_89AB_CDEF;
    q_req.push_back('{we: 1'b0, addr: 20'h0ABCD, wdata: '0});
    q_rd.push_back(64'h0123_4567_89AB_CDEF);
    launch(1);
    run_txn(0, 1, 0, n);
    total++;
    if (n !== 1) begin bad++; $display("FAIL collision_cycles got=%0d want=1", n); end
  endtask

  task automatic test_reset_mid;
    q_req.push_back('{we: 1'b1, addr: 20'h0ABCD, wdata: 64'hFFFF});
    launch(0);
    tick;
    // rd edge while busy: flagged, transaction undisturbed
    i_wr = 0; i_rd = 1; i_wrx = 1; i_arx = 2'd3;
    tick;
    clear_strobes();
    total++;
    if (o_err !== 1'b1 || o_mem_valid !== 1'b1 || o_mem_we !== 1'b1) begin
      bad++; $display("FAIL busy_edge got err=%0b valid=%0b we=%0b want 1/1/1", o_err, o_mem_valid, o_mem_we);
    end
    reset = 1;
    tick;
    reset = 0;
    void'(q_req.pop_front());
    check_regs_zero("reset_mid");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_illegal();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
